uart_rx_tx_fifo: RTL and testbench

UART_RX_TX_FIFO -- requirements
Module: uart_rx_tx_fifo

---
 rtl/uart_rx_tx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_tx_fifo.sv
// Synchronous FIFO with occupancy flags and sticky error flags.
// FWFT selects registered read or first-word-fall-through output.
module uart_rx_tx_fifo #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_FIFO  = 16,
  parameter int ADDR_WIDTH = $clog2(SIZE_FIFO),
  parameter int AF_LEVEL   = SIZE_FIFO - 2,
  parameter int AE_LEVEL   = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  write,
  input  logic                  read,
  input  logic                  clr_err,
  output logic [DATA_SIZE-1:0]  data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(SIZE_FIFO);
  localparam logic [CW-1:0] LP_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] LP_AE    = CW'(AE_LEVEL);

  logic [DATA_SIZE-1:0]  r_mem [SIZE_FIFO];
  logic [ADDR_WIDTH-1:0] r_ptr_wr;
  logic [ADDR_WIDTH-1:0] r_ptr_rd;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [CW-1:0]         w_count_nxt;
  logic [DATA_SIZE-1:0]  w_rd_word;

  // Flags come from registered count only
  assign w_full  = (r_count == LP_DEPTH);
  assign w_empty = (r_count == '0);

  assign w_wr_acc  = write & (~w_full | read) & ~flush;
  assign w_rd_acc  = read & ~w_empty & ~flush;
  assign w_ovf_set = write & w_full & ~read;
  assign w_unf_set = read & w_empty;

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      (w_wr_acc & ~w_rd_acc): w_count_nxt = r_count + CW'(1);
      (~w_wr_acc & w_rd_acc): w_count_nxt = r_count - CW'(1);
      default:                w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr_wr <= '0;
      r_ptr_rd <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_ptr_wr <= '0;
      r_ptr_rd <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_ptr_wr <= r_ptr_wr + ADDR_WIDTH'(1);
      if (w_rd_acc) r_ptr_rd <= r_ptr_rd + ADDR_WIDTH'(1);
      r_count <= w_count_nxt;
    end
  end

  // Set beats clear; flush leaves the error flags alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!flush) begin
      if (w_ovf_set)    r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_unf_set)    r_unf <= 1'b1;
      else if (clr_err) r_unf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_ptr_wr] <= data_in;
  end

  assign w_rd_word = r_mem[r_ptr_rd];

  generate
    if (FWFT) begin : g_fwft
      assign data_out = w_empty ? '0 : w_rd_word;
    end else begin : g_reg
      logic [DATA_SIZE-1:0] r_dout;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_rd_word;
      end
      assign data_out = r_dout;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_uart_rx_tx_fifo.sv
// Scoreboard bench for uart_rx_tx_fifo: registered and FWFT
// instances driven by directed vectors.
module tb_uart_rx_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] data_in = '0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  logic [7:0] f_data_in = '0;
  logic       f_write = 1'b0;
  logic       f_read = 1'b0;
  logic [7:0] f_data_out;
  logic       f_full, f_empty, f_af, f_ae;
  logic [4:0] f_count;
  logic       f_ovf, f_unf;

  int n_chk = 0;
  int n_pass = 0;
  logic exp_rd = 1'b0;
  logic [7:0] q_exp [$];

  always #5 clk = ~clk;

  uart_rx_tx_fifo dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .data_in(data_in), .write(write), .read(read),
    .clr_err(clr_err), .data_out(data_out),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  uart_rx_tx_fifo #(.FWFT(1'b1)) dut_f (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .data_in(f_data_in), .write(f_write), .read(f_read),
    .clr_err(clr_err), .data_out(f_data_out),
    .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step(input logic w, input logic r,
                      input logic [7:0] d, input logic fl,
                      input logic cl, input logic ev,
                      input logic [7:0] ed);
    write = w; read = r; data_in = d;
    flush = fl; clr_err = cl; exp_rd = ev;
    if (ev) q_exp.push_back(ed);
    @(negedge clk);
    write = 0; read = 0; data_in = '0;
    flush = 0; clr_err = 0; exp_rd = 0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1, 0, d, 0, 0, 0, '0);
  endtask

  task automatic rd(input logic [7:0] ed);
    step(0, 1, '0, 0, 0, 1, ed);
  endtask

  task automatic clr();
    step(0, 0, '0, 0, 1, 0, '0);
  endtask

  initial begin : monitor
    logic p;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      p = exp_rd;
      @(negedge clk);
      if (p) begin
        if (q_exp.size() == 0) begin
          n_chk++;
          $display("FAIL mon_underrun: got read with empty queue");
        end else begin
          e = q_exp.pop_front();
          chk("rd_data", {24'd0, data_out}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_f_dout", f_data_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // In-order fill and drain
    for (int i = 0; i < 16; i++) wr(8'(i));
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    for (int i = 0; i < 16; i++) rd(8'(i));
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("drain_ovf", overflow, 0);
    chk("drain_unf", underflow, 0);

    // Overflow
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    wr(8'hAA);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) rd(8'(8'h20 + i));
    chk("ovf_hold", overflow, 1);
    clr();
    chk("ovf_clr", overflow, 0);

    // Simultaneous read/write while full, across wrap
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 8'(8'h50 + i), 0, 0, 1,
           (i < 16) ? 8'(8'h40 + i) : 8'(8'h50 + i - 16));
      chk("rw_count", count, 16);
      chk("rw_full", full, 1);
    end
    chk("rw_ovf", overflow, 0);
    for (int i = 4; i < 20; i++) rd(8'(8'h50 + i));
    chk("rw_empty", empty, 1);

    // Write+read while empty
    step(1, 1, 8'h5C, 0, 0, 0, '0);
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 1);
    rd(8'h5C);
    chk("unf_drain", count, 0);
    step(0, 1, '0, 0, 1, 0, '0);
    chk("unf_set_wins", underflow, 1);
    clr();
    chk("unf_clr", underflow, 0);

    // Threshold flags and flush
    for (int k = 1; k <= 16; k++) begin
      wr(8'(8'h70 + k - 1));
      chk("up_af", almost_full, (k >= 14));
      chk("up_ae", almost_empty, (k <= 2));
    end
    wr(8'hEE);
    chk("af_ovf", overflow, 1);
    for (int j = 1; j <= 7; j++) begin
      rd(8'(8'h70 + j - 1));
      chk("dn_af", almost_full, ((16 - j) >= 14));
      chk("dn_ae", almost_empty, ((16 - j) <= 2));
    end
    chk("pre_flush_cnt", count, 9);
    step(1, 0, 8'h99, 1, 0, 0, '0);
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 1);
    chk("flush_unf", underflow, 0);
    chk("flush_dout", data_out, 8'h76);
    clr();

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) wr(8'(8'hC0 + i));
    rd(8'hC0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", data_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // First-word-fall-through instance
    chk("fw_empty0", f_data_out, 0);
    f_write = 1'b1; f_data_in = 8'h11;
    @(negedge clk);
    f_write = 1'b0; f_data_in = '0;
    chk("fw_dout", f_data_out, 8'h11);
    chk("fw_nempty", f_empty, 0);
    f_read = 1'b1;
    @(negedge clk);
    f_read = 1'b0;
    chk("fw_empty", f_empty, 1);
    chk("fw_dout0", f_data_out, 0);

    step(0, 0, '0, 0, 0, 0, '0);
    step(0, 0, '0, 0, 0, 0, '0);
    chk("q_drained", q_exp.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
